// File: rtl/ac_pkg.sv
// Shared encodings for the accumulator-machine control sequencer.
// Opcodes, bus/ALU selects and sequencer states live here.
package ac_pkg;

    localparam int REG_WIDTH = 12;
    localparam int OPC_WIDTH = 4;

    typedef enum logic [OPC_WIDTH-1:0] {
        OP_NOP   = 4'd0,
        OP_LOAD  = 4'd1,
        OP_STORE = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_AND   = 4'd5,
        OP_JMP   = 4'd6,
        OP_JMPZ  = 4'd7,
        OP_CLR   = 4'd8,
        OP_INC   = 4'd9,
        OP_HALT  = 4'd15
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_CLR  = 3'd4,
        ALU_INC  = 3'd5
    } alu_e;

    typedef enum logic [2:0] {
        BUS_NONE = 3'd0,
        BUS_PC   = 3'd1,
        BUS_IR   = 3'd2,
        BUS_AC   = 3'd3,
        BUS_MDR  = 3'd4
    } bus_e;

    typedef enum logic [2:0] {
        FETCH_ADDR = 3'd0,
        FETCH_MEM  = 3'd1,
        DECODE     = 3'd2,
        OPER_ADDR  = 3'd3,
        OPER_MEM   = 3'd4,
        HALTED     = 3'd5
    } state_e;

endpackage

// File: rtl/ac_sequencer.sv
// Control sequencer for a single-accumulator machine: fetch,
// decode and memory-operand execution with a retired-instruction count.
module ac_sequencer
    import ac_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OPC_WIDTH-1:0] opcode,
    input  logic                 ac_zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 mar_load,
    output logic                 ir_load,
    output logic                 pc_inc,
    output logic                 pc_load,
    output logic                 ac_write_en,
    output logic [2:0]           bus_sel,
    output logic [2:0]           alu_op,
    output logic                 halted,
    output logic                 illegal,
    output logic [15:0]          instr_count
);

    state_e      state_q, state_d;
    logic        illegal_q, illegal_d;
    logic [15:0] count_q, count_d;
    opcode_e     opc;

    assign opc = opcode_e'(opcode);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH_ADDR;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        unique case (state_q)
            FETCH_ADDR: state_d = FETCH_MEM;
            FETCH_MEM:  if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (opc)
                    OP_NOP, OP_CLR, OP_INC,
                    OP_JMP, OP_JMPZ: state_d = FETCH_ADDR;
                    OP_LOAD, OP_STORE, OP_ADD,
                    OP_SUB, OP_AND:  state_d = OPER_ADDR;
                    OP_HALT:         state_d = HALTED;
                    default: begin
                        state_d   = HALTED;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            OPER_ADDR:  state_d = OPER_MEM;
            OPER_MEM:   if (mem_ready) state_d = FETCH_ADDR;
            HALTED:     state_d = HALTED;
            default:    state_d = FETCH_ADDR;
        endcase
        // An instruction retires whenever control returns to fetch.
        count_d = count_q;
        if (state_d == FETCH_ADDR &&
            (state_q == DECODE || state_q == OPER_MEM))
            count_d = count_q + 16'd1;
    end

    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mar_load    = 1'b0;
        ir_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        ac_write_en = 1'b0;
        bus_sel     = BUS_NONE;
        alu_op      = ALU_PASS;
        unique case (state_q)
            FETCH_ADDR: begin
                bus_sel  = BUS_PC;
                mar_load = 1'b1;
            end
            FETCH_MEM: begin
                mem_req = 1'b1;
                ir_load = mem_ready;
                pc_inc  = mem_ready;
            end
            DECODE: begin
                case (opc)
                    OP_CLR: begin
                        ac_write_en = 1'b1;
                        alu_op      = ALU_CLR;
                    end
                    OP_INC: begin
                        ac_write_en = 1'b1;
                        alu_op      = ALU_INC;
                    end
                    OP_JMP: begin
                        bus_sel = BUS_IR;
                        pc_load = 1'b1;
                    end
                    OP_JMPZ: begin
                        bus_sel = BUS_IR;
                        pc_load = ac_zero;
                    end
                    default: ;
                endcase
            end
            OPER_ADDR: begin
                bus_sel  = BUS_IR;
                mar_load = 1'b1;
            end
            OPER_MEM: begin
                mem_req = 1'b1;
                if (opc == OP_STORE) begin
                    mem_we  = 1'b1;
                    bus_sel = BUS_AC;
                end else begin
                    bus_sel     = BUS_MDR;
                    ac_write_en = mem_ready;
                    if (mem_ready) begin
                        case (opc)
                            OP_ADD:  alu_op = ALU_ADD;
                            OP_SUB:  alu_op = ALU_SUB;
                            OP_AND:  alu_op = ALU_AND;
                            default: alu_op = ALU_PASS;
                        endcase
                    end
                end
            end
            HALTED:  ;
            default: ;
        endcase
    end

    assign halted      = (state_q == HALTED);
    assign illegal     = illegal_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_ac_sequencer.sv
// Directed bench for ac_sequencer: per-cycle expected outputs are
// queued as stimulus is applied and checked at the falling edge.
module tb_ac_sequencer;

    typedef struct packed {
        logic        mreq;
        logic        mwe;
        logic        mar;
        logic        ir;
        logic        pci;
        logic        pcl;
        logic        acw;
        logic [2:0]  bus;
        logic [2:0]  alu;
        logic        hlt;
        logic        ill;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  opcode;
    logic        ac_zero;
    logic        mem_ready;
    logic        mem_req, mem_we, mar_load, ir_load, pc_inc;
    logic        pc_load, ac_write_en, halted, illegal;
    logic [2:0]  bus_sel, alu_op;
    logic [15:0] instr_count;

    int checks = 0;
    int errors = 0;
    exp_t  exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    ac_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .ac_zero     (ac_zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mar_load    (mar_load),
        .ir_load     (ir_load),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .ac_write_en (ac_write_en),
        .bus_sel     (bus_sel),
        .alu_op      (alu_op),
        .halted      (halted),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    function automatic exp_t e(
        input logic mreq, mwe, mar, ir, pci, pcl, acw,
        input logic [2:0] bus, alu,
        input logic hlt, ill,
        input logic [15:0] cnt);
        e = '{mreq, mwe, mar, ir, pci, pcl, acw, bus, alu, hlt, ill, cnt};
    endfunction

    function automatic exp_t fa(input logic [15:0] c);
        fa = e(0,0,1,0,0,0,0,3'd1,3'd0,0,0,c);
    endfunction

    function automatic exp_t fm(input logic r, input logic [15:0] c);
        fm = e(1,0,0,r,r,0,0,3'd0,3'd0,0,0,c);
    endfunction

    function automatic exp_t idle(input logic [15:0] c);
        idle = e(0,0,0,0,0,0,0,3'd0,3'd0,0,0,c);
    endfunction

    function automatic exp_t oa(input logic [15:0] c);
        oa = e(0,0,1,0,0,0,0,3'd2,3'd0,0,0,c);
    endfunction

    task automatic step(input string tag, input logic rdy,
                        input logic [3:0] opc, input exp_t ex);
        exp_t  got, want;
        string t;
        opcode    = opc;
        mem_ready = rdy;
        exp_q.push_back(ex);
        tag_q.push_back(tag);
        @(negedge clk);
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        got  = '{mem_req, mem_we, mar_load, ir_load, pc_inc, pc_load,
                 ac_write_en, bus_sel, alu_op, halted, illegal,
                 instr_count};
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", t, got, want);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = 4'd0;
        ac_zero   = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step("reset_state", 1, 4'd0, fa(0));
        reset = 1'b0;

        step("nop_fa",  0, 4'd0, fa(0));
        step("nop_fm",  1, 4'd0, fm(1, 0));
        step("nop_dec", 0, 4'd0, idle(0));

        step("clr_fa",    1, 4'd8, fa(1));
        step("clr_fwait", 0, 4'd8, fm(0, 1));
        step("clr_fm",    1, 4'd8, fm(1, 1));
        step("clr_dec",   0, 4'd8, e(0,0,0,0,0,0,1,3'd0,3'd4,0,0,1));

        step("inc_fa",  0, 4'd9, fa(2));
        step("inc_fm",  1, 4'd9, fm(1, 2));
        step("inc_dec", 1, 4'd9, e(0,0,0,0,0,0,1,3'd0,3'd5,0,0,2));

        step("add_fa",  0, 4'd3, fa(3));
        step("add_fm",  1, 4'd3, fm(1, 3));
        step("add_dec", 0, 4'd3, idle(3));
        step("add_oa",  1, 4'd3, oa(3));
        for (int i = 0; i < 3; i++)
            step("add_owait", 0, 4'd3, e(1,0,0,0,0,0,0,3'd4,3'd0,0,0,3));
        step("add_om",  1, 4'd3, e(1,0,0,0,0,0,1,3'd4,3'd1,0,0,3));

        step("st_fa",    0, 4'd2, fa(4));
        step("st_fm",    1, 4'd2, fm(1, 4));
        step("st_dec",   0, 4'd2, idle(4));
        step("st_oa",    0, 4'd2, oa(4));
        step("st_owait", 0, 4'd2, e(1,1,0,0,0,0,0,3'd3,3'd0,0,0,4));
        step("st_om",    1, 4'd2, e(1,1,0,0,0,0,0,3'd3,3'd0,0,0,4));

        step("ld_fa",  0, 4'hA, fa(5));
        step("ld_fm",  1, 4'hA, fm(1, 5));
        step("ld_dec", 0, 4'd1, idle(5));
        step("ld_oa",  0, 4'd1, oa(5));
        step("ld_om",  1, 4'd1, e(1,0,0,0,0,0,1,3'd4,3'd0,0,0,5));

        ac_zero = 1'b1;
        step("jz1_fa",  0, 4'd7, fa(6));
        step("jz1_fm",  1, 4'd7, fm(1, 6));
        step("jz1_dec", 0, 4'd7, e(0,0,0,0,0,1,0,3'd2,3'd0,0,0,6));
        ac_zero = 1'b0;
        step("jz0_fa",  0, 4'd7, fa(7));
        step("jz0_fm",  1, 4'd7, fm(1, 7));
        step("jz0_dec", 0, 4'd7, e(0,0,0,0,0,0,0,3'd2,3'd0,0,0,7));

        step("jmp_fa",  0, 4'd6, fa(8));
        step("jmp_fm",  1, 4'd6, fm(1, 8));
        step("jmp_dec", 0, 4'd6, e(0,0,0,0,0,1,0,3'd2,3'd0,0,0,8));

        step("and_fa",  0, 4'd5, fa(9));
        step("and_fm",  1, 4'd5, fm(1, 9));
        step("and_dec", 0, 4'd5, idle(9));
        step("and_oa",  0, 4'd5, oa(9));
        step("and_om",  1, 4'd5, e(1,0,0,0,0,0,1,3'd4,3'd3,0,0,9));

        step("sub_fa",  0, 4'd4, fa(10));
        step("sub_fm",  1, 4'd4, fm(1, 10));
        step("sub_dec", 0, 4'd4, idle(10));
        step("sub_oa",  0, 4'd4, oa(10));
        step("sub_om",  1, 4'd4, e(1,0,0,0,0,0,1,3'd4,3'd2,0,0,10));

        step("rst_fa", 0, 4'd0, fa(11));
        reset = 1'b1;
        step("rst_fwait", 1, 4'd0, fm(1, 11));
        reset = 1'b0;
        step("rst_after", 0, 4'd0, fa(0));
        step("rst_fm",    1, 4'd0, fm(1, 0));
        step("rst_dec",   0, 4'd0, idle(0));

        step("ill_fa",  0, 4'hA, fa(1));
        step("ill_fm",  1, 4'hA, fm(1, 1));
        step("ill_dec", 0, 4'hA, idle(1));
        for (int i = 0; i < 10; i++)
            step("ill_halt", 1, 4'hA, e(0,0,0,0,0,0,0,3'd0,3'd0,1,1,1));
        reset = 1'b1;
        step("ill_rst", 1, 4'hA, e(0,0,0,0,0,0,0,3'd0,3'd0,1,1,1));
        reset = 1'b0;
        step("ill_clear", 0, 4'hF, fa(0));

        step("hlt_fm",  1, 4'hF, fm(1, 0));
        step("hlt_dec", 0, 4'hF, idle(0));
        for (int i = 0; i < 3; i++)
            step("hlt_halt", 1, 4'd6, e(0,0,0,0,0,0,0,3'd0,3'd0,1,0,0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ac_sequencer.md
AC_SEQUENCER -- requirements
Module: ac_sequencer

Interface
REG-P1: REG_WIDTH, 12, datapath/bus width.
REG-P2: OPC_WIDTH, 4, opcode field width in IR[REG_WIDTH-1 -: OPC_WIDTH].
REQ-001 SHALL provide: clk  input  1  system clock, rising-edge.
REQ-002 SHALL provide: reset  input  1  synchronous, active-high.
REQ-003 SHALL provide: opcode  input  OPC_WIDTH  IR opcode field.
REQ-004 SHALL provide: ac_zero  input  1  high when accumulator equals 0.
REQ-005 SHALL provide: mem_ready  input  1  memory completion strobe.
REQ-006 SHALL provide: mem_req / mem_we  output  1 each  memory request / write qualifier.
REQ-007 SHALL provide: mar_load, ir_load, pc_inc, pc_load, ac_write_en  output  1 each  datapath load strobes.
REQ-008 SHALL provide: bus_sel  output  3  bus driver select: 0 none, 1 PC, 2 IR operand, 3 AC, 4 MDR.
REQ-009 SHALL provide: alu_op  output  3  0 PASS, 1 ADD, 2 SUB, 3 AND, 4 CLR, 5 INC.
REQ-010 SHALL provide: halted, illegal  output  1 each  status; instr_count  output  16  retired-instruction count.

Function
REQ-011 SHALL implement states FETCH_ADDR, FETCH_MEM, DECODE, OPER_ADDR, OPER_MEM, HALTED.
REQ-012 FETCH_ADDR: bus_sel=1, mar_load=1; next FETCH_MEM.
REQ-013 FETCH_MEM: mem_req=1, mem_we=0; on mem_ready: ir_load=1, pc_inc=1, next DECODE; else hold.
REQ-014 DECODE by opcode: 0 NOP, 8 CLR (ac_write_en, alu_op=4), 9 INC (ac_write_en, alu_op=5), 6 JMP (bus_sel=2, pc_load=1) -> FETCH_ADDR in all four cases.
REQ-015 DECODE opcode 7 JMPZ: pc_load=ac_zero, bus_sel=2; next FETCH_ADDR.
REQ-016 DECODE opcodes 1 LOAD, 2 STORE, 3 ADD, 4 SUB, 5 AND -> OPER_ADDR; 15 HALT -> HALTED; others -> HALTED with illegal set.
REQ-017 OPER_ADDR: bus_sel=2, mar_load=1; next OPER_MEM.
REQ-018 OPER_MEM: mem_req=1; STORE drives mem_we=1, bus_sel=3; others mem_we=0, bus_sel=4; on mem_ready non-STORE asserts ac_write_en with alu_op PASS/ADD/SUB/AND for opcodes 1/3/4/5; next FETCH_ADDR; else hold with outputs stable.
REQ-019 Outputs SHALL be decoded from current state and opcode only; unlisted strobes 0, bus_sel=0, alu_op=0.
REQ-020 Latency with zero-wait memory: NOP/CLR/INC/JMP/JMPZ 3 cycles, memory-operand instructions 5 cycles; each mem wait cycle adds 1.
REQ-021 mem_ready outside FETCH_MEM/OPER_MEM SHALL be ignored.
REQ-022 mem_req SHALL remain high continuously until the mem_ready cycle, deasserting the following cycle.
REQ-023 instr_count SHALL increment by 1 on each transition into FETCH_ADDR from DECODE or OPER_MEM, wrapping 0xFFFF->0x0000.
REQ-024 HALTED: all strobes 0, halted=1; exit only via reset.
REQ-025 opcode SHALL be sampled only in DECODE/OPER_MEM; changes elsewhere have no effect.

Reset
REQ-026 On reset, state=FETCH_ADDR, instr_count=0, halted=0, illegal=0 at next rising edge; reset mid-memory-cycle drops mem_req that edge.
REQ-027 Reset SHALL take priority over mem_ready and all transitions.

Structure
REQ-028 Opcode, alu_op, bus_sel encodings and state enum SHALL reside in shared package ac_pkg.
REQ-029 Single module; no sub-modules; one state register plus counter.

Verification
REQ-030 NOP, zero-wait: reset release -> mar_load cycle 1, ir_load+pc_inc cycle 2, instr_count=1 after cycle 3.
REQ-031 ADD with mem_ready delayed 3 cycles in OPER_MEM -> mem_req high 4 cycles, single ac_write_en with alu_op=1, bus_sel=4.
REQ-032 STORE -> mem_we=1, bus_sel=3 during OPER_MEM, ac_write_en never asserted.
REQ-033 JMPZ with ac_zero=1 then 0 -> pc_load=1 once, pc_load=0 once, bus_sel=2 both.
REQ-034 Opcode 0xA -> halted=1, illegal=1, strobes 0 for 10 cycles; reset -> FETCH_ADDR, illegal=0.
REQ-035 Reset asserted in FETCH_MEM with mem_req high -> mem_req=0 next cycle, instr_count=0, then fetch resumes.
